// File: rtl/riscv_pkg.sv
// Shared RV32M divider definitions: funct3 encodings, FSM state type and default width.
package riscv_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIN} div_state_t;

endpackage

// File: rtl/int_div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed overflow resolved in a single cycle.
module int_div_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state_q;
  logic            busy_q, done_q;
  logic [XLEN-1:0] result_q, quo_q, rem_q, dvsr_q;
  logic [CW-1:0]   count_q;
  logic            rem_op_q, quo_neg_q, rem_neg_q;

  logic            is_signed, is_rem, a_neg, b_neg, div_zero, overflow;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  // funct3[2]=0 falls through as an unsigned quotient request.
  assign is_signed   = funct3[2] & ~funct3[0];
  assign is_rem      = funct3[2] & funct3[1];
  assign a_neg       = is_signed & dividend[XLEN-1];
  assign b_neg       = is_signed & divisor[XLEN-1];
  assign a_mag       = a_neg ? -dividend : dividend;
  assign b_mag       = b_neg ? -divisor : divisor;
  assign div_zero    = (divisor == '0);
  assign overflow    = is_signed && (dividend == MIN_NEG) && (divisor == '1);
  assign special_res = div_zero ? (is_rem ? dividend : '1) : (is_rem ? '0 : dividend);

  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] quo_d, rem_d, q_fin, r_fin;

  // The XLEN+1-bit difference carries the sign used to decide restore vs keep.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvsr_q};
    rem_d   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quo_d   = {quo_q[XLEN-2:0], ~diff[XLEN]};
    q_fin   = quo_neg_q ? -quo_d : quo_d;
    r_fin   = rem_neg_q ? -rem_d : rem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      count_q   <= '0;
      rem_op_q  <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          CALC: begin
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            count_q <= count_q - 1'b1;
            if (count_q == '0) begin
              state_q  <= FIN;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= rem_op_q ? r_fin : q_fin;
            end
          end
          default: begin
            // IDLE and FIN both accept; FIN accepting gives back-to-back issue.
            if (start) begin
              rem_op_q  <= is_rem;
              quo_neg_q <= a_neg ^ b_neg;
              rem_neg_q <= a_neg;
              if (div_zero || overflow) begin
                state_q  <= FIN;
                done_q   <= 1'b1;
                result_q <= special_res;
              end else begin
                state_q <= CALC;
                busy_q  <= 1'b1;
                quo_q   <= a_mag;
                rem_q   <= '0;
                dvsr_q  <= b_mag;
                count_q <= CNT_INIT;
              end
            end else begin
              state_q <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_int_div_unit.sv
// Self-checking bench for int_div_unit: directed table, handshake corner cases,
// and random operations against an arithmetic reference model.
module tb_int_div_unit;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'b101;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  int_div_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .dividend(dividend), .divisor(divisor), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    bit sgn;
    bit rem;
    int sa;
    int sb;
    sgn = (f3 == 3'b100) || (f3 == 3'b110);
    rem = (f3 == 3'b110) || (f3 == 3'b111);
    sa  = a;
    sb  = b;
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : a;
      return rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return rem ? a % b : a / b;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit sgn;
    sgn = (f3 == 3'b100) || (f3 == 3'b110);
    if (b == 0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Leaves the bench in cycle N+1 of the accepted operation.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    funct3   = f3;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 1;
    busy_cycles = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cycles++;
      tick();
      lat++;
    end
  endtask

  task automatic run_one(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    int bc;
    issue(f3, a, b);
    wait_done(lat, bc);
    $display("op %s f3=%b a=%h b=%h -> result=%h lat=%0d (exp %h lat %0d)",
             name, f3, a, b, result, lat, exp, exp_lat);
    check({name, " result"}, result, exp);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " busy cycles"}, 32'(bc), 32'(exp_lat - 1));
    check({name, " busy@done"}, {31'b0, busy}, 32'h0);
    tick();
    check({name, " done width"}, {31'b0, done}, 32'h0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic quiet_window(input string name, input logic [31:0] exp_res);
    int dones = 0;
    int busys = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      if (busy) busys++;
      tick();
    end
    $display("idle window %s: dones=%0d busy_cycles=%0d result=%h", name, dones, busys, result);
    check({name, " no done"}, 32'(dones), 32'h0);
    check({name, " no busy"}, 32'(busys), 32'h0);
    check({name, " result held"}, result, exp_res);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int lat;
    int bc;

    vecs.push_back('{3'b101, 32'd100,        32'd7,          32'd14,         33});
    vecs.push_back('{3'b111, 32'd100,        32'd7,          32'd2,          33});
    vecs.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
    vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
    vecs.push_back('{3'b110, 32'd7,          32'hFFFF_FFFE,  32'd1,          33});
    vecs.push_back('{3'b100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33});
    vecs.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
    vecs.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1});
    vecs.push_back('{3'b101, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{3'b111, 32'd5,          32'd0,          32'd5,          1});
    vecs.push_back('{3'b100, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{3'b110, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1});
    vecs.push_back('{3'b100, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          33});
    vecs.push_back('{3'b110, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'hFFFF_FFFE,  33});
    vecs.push_back('{3'b101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33});
    vecs.push_back('{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33});

    // Reset state
    repeat (2) tick();
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset done", {31'b0, done}, 32'h0);
    check("reset result", result, 32'h0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i])
      run_one($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Start pulsed mid-operation is dropped; original op completes once.
    issue(3'b101, 32'd1000, 32'd3);
    c = 1;
    while (!done && c < 100) begin
      if (c == 10) begin
        funct3 = 3'b101; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      c++;
    end
    start = 1'b0;
    $display("op ignored-start DIVU 1000/3 -> result=%h lat=%0d", result, c);
    check("ignored start latency", 32'(c), 32'd33);
    check("ignored start result", result, 32'd333);
    tick();
    quiet_window("after ignored start", 32'd333);

    // Flush at +20 kills the op without a done and leaves result alone.
    issue(3'b101, 32'd1000, 32'd7);
    c = 1;
    bc = 0;
    while (c < 25) begin
      flush = (c == 20);
      if (done) bc++;
      tick();
      c++;
    end
    flush = 1'b0;
    check("flush no early done", 32'(bc), 32'h0);
    quiet_window("after flush", 32'd333);
    run_one("post-flush", 3'b101, 32'd1000, 32'd7, 32'd142, 33);

    // Flush wins over start in the same cycle.
    funct3 = 3'b101; dividend = 32'd50; divisor = 32'd5; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    quiet_window("flush vs start", 32'd142);

    // Asynchronous reset mid-operation.
    issue(3'b101, 32'd50, 32'd5);
    repeat (14) tick();
    rst_n = 1'b0;
    #1;
    $display("async reset at +15: busy=%b done=%b result=%h", busy, done, result);
    check("async rst busy", {31'b0, busy}, 32'h0);
    check("async rst done", {31'b0, done}, 32'h0);
    check("async rst result", result, 32'h0);
    tick();
    rst_n = 1'b1;
    quiet_window("after reset", 32'h0);

    // Back-to-back: each new start is issued in the previous done cycle.
    issue(3'b101, 32'd100, 32'd7);
    wait_done(lat, bc);
    check("b2b op1 result", result, 32'd14);
    check("b2b op1 latency", 32'(lat), 32'd33);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2);
    check("b2b op2 no stale done", {31'b0, done}, 32'h0);
    wait_done(lat, bc);
    $display("op b2b REM -7/2 -> result=%h lat=%0d", result, lat);
    check("b2b op2 result", result, 32'hFFFF_FFFF);
    check("b2b op2 latency", 32'(lat), 32'd33);
    issue(3'b111, 32'd5, 32'd0);
    wait_done(lat, bc);
    $display("op b2b REMU 5/0 -> result=%h lat=%0d", result, lat);
    check("b2b op3 result", result, 32'd5);
    check("b2b op3 latency", 32'(lat), 32'd1);
    issue(3'b100, 32'd100, 32'hFFFF_FFF9);
    wait_done(lat, bc);
    $display("op b2b DIV 100/-7 -> result=%h lat=%0d", result, lat);
    check("b2b op4 result", result, 32'hFFFF_FFF2);
    check("b2b op4 latency", 32'(lat), 32'd33);
    tick();
    check("b2b done width", {31'b0, done}, 32'h0);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 50; i++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      f3 = {1'b1, 2'($urandom_range(0, 3))};
      a  = pick_operand();
      b  = pick_operand();
      run_one($sformatf("rnd%0d", i), f3, a, b, ref_model(f3, a, b), ref_lat(f3, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
